fifo_row_collector: RTL and testbench

- Reader end of the Fifo/OutputFifo streaming interface used by the matrix-computation datapath.
- Drains scalar matrix elements from a FIFO's read side and packs COLS consecutive elements into one row word.
- Presents each row on a valid/ready port to the next stage (row-wise writeback or a systolic feeder).
- Counts rows and signals completion after a programmed number of rows.

---
 rtl/fifo_row_collector_pkg.sv | 31 +++
 rtl/fifo_row_collector.sv | 175 +++++++++++++++++
 tb/tb_fifo_row_collector.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_row_collector_pkg.sv
// Shared types and sizing helpers for the FIFO row collector.
package fifo_row_collector_pkg;

  // Collector control states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_EMIT    = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Column counter width: clog2(cols), never narrower than one bit.
  function automatic int col_cnt_width(input int cols);
    int w;
    w = $clog2(cols);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

  // Default geometry of the matrix datapath.
  localparam int DEF_WIDTH     = 8;
  localparam int DEF_COLS      = 4;
  localparam int DEF_ROW_CNT_W = 8;
  localparam int ROW_W         = DEF_WIDTH * DEF_COLS;
  localparam int COL_CNT_W     = col_cnt_width(DEF_COLS);

endpackage

// File: rtl/fifo_row_collector.sv
// Drains scalar elements from a FIFO read port, packs COLS of them into a
// row word and hands each row downstream over valid/ready. Signals done
// after the programmed number of rows has been accepted.
module fifo_row_collector
  import fifo_row_collector_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int COLS      = 4,
  parameter int ROW_CNT_W = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      start,
  input  logic [ROW_CNT_W-1:0]      num_rows,
  input  logic                      fifo_read_ready,
  input  logic [WIDTH-1:0]          fifo_read_data,
  output logic                      fifo_read_enable,
  output logic                      row_valid,
  output logic [WIDTH*COLS-1:0]     row_data,
  output logic [ROW_CNT_W-1:0]      row_index,
  input  logic                      row_ready,
  output logic                      busy,
  output logic                      done
);

  localparam int ROW_BITS = WIDTH * COLS;
  localparam int CC_W     = col_cnt_width(COLS);
  localparam logic [CC_W-1:0]      COL_LAST = CC_W'(COLS - 1);
  localparam logic [ROW_CNT_W-1:0] ROW_ONE  = ROW_CNT_W'(1);
  localparam logic [ROW_CNT_W-1:0] ROW_ZERO = ROW_CNT_W'(0);

  state_t                 state_r;
  state_t                 state_s;
  logic [CC_W-1:0]        col_cnt_r;
  logic [ROW_CNT_W-1:0]   row_idx_r;
  logic [ROW_CNT_W-1:0]   num_rows_r;
  logic [ROW_BITS-1:0]    row_data_r;

  logic                   start_ok_s;
  logic                   pop_s;
  logic                   accept_s;
  logic                   last_col_s;
  logic                   last_row_s;

  // Qualify the events the FSM and datapath react to this cycle.
  always_comb begin
    start_ok_s = 1'b0;
    pop_s      = 1'b0;
    accept_s   = 1'b0;
    last_col_s = (col_cnt_r == COL_LAST);
    last_row_s = (row_idx_r == (num_rows_r - ROW_ONE));
    if (state_r == ST_IDLE) begin
      start_ok_s = start;
    end else if (state_r == ST_COLLECT) begin
      pop_s = fifo_read_ready;
    end else if (state_r == ST_EMIT) begin
      accept_s = row_ready;
    end else begin
      start_ok_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) begin
          if (num_rows != ROW_ZERO) begin
            state_s = ST_COLLECT;
          end else begin
            state_s = ST_DONE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (pop_s && last_col_s) begin
          state_s = ST_EMIT;
        end else begin
          state_s = ST_COLLECT;
        end
      end
      ST_EMIT: begin
        if (accept_s) begin
          if (last_row_s) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_COLLECT;
          end
        end else begin
          state_s = ST_EMIT;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output decode; the FIFO strobe follows read_ready in the same cycle.
  always_comb begin
    fifo_read_enable = 1'b0;
    row_valid        = 1'b0;
    busy             = 1'b1;
    done             = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy = 1'b0;
      end
      ST_COLLECT: begin
        fifo_read_enable = fifo_read_ready;
      end
      ST_EMIT: begin
        row_valid = 1'b1;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Job setup, lane packing and row/column counting.
  always_ff @(posedge CLK) begin
    if (RST) begin
      col_cnt_r  <= '0;
      row_idx_r  <= '0;
      num_rows_r <= '0;
      row_data_r <= '0;
    end else if (start_ok_s) begin
      col_cnt_r <= '0;
      row_idx_r <= '0;
      if (num_rows != ROW_ZERO) begin
        num_rows_r <= num_rows;
      end else begin
        num_rows_r <= num_rows_r;
      end
    end else if (pop_s) begin
      for (int l = 0; l < COLS; l++) begin
        if (col_cnt_r == CC_W'(l)) begin
          row_data_r[l*WIDTH +: WIDTH] <= fifo_read_data;
        end
      end
      if (last_col_s) begin
        col_cnt_r <= '0;
      end else begin
        col_cnt_r <= col_cnt_r + CC_W'(1);
      end
    end else if (accept_s && !last_row_s) begin
      row_idx_r <= row_idx_r + ROW_ONE;
    end else begin
      row_idx_r <= row_idx_r;
    end
  end

  assign row_data  = row_data_r;
  assign row_index = row_idx_r;

endmodule

// File: tb/tb_fifo_row_collector.sv
// Self-checking bench for fifo_row_collector: a queue-based FIFO, an
// abstract job/row scoreboard checked every cycle, and directed scenarios
// with hand-computed row words.
module tb_fifo_row_collector;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [7:0]  num_rows;
  logic        fifo_read_ready;
  logic [7:0]  fifo_read_data;
  logic        fifo_read_enable;
  logic        row_valid;
  logic [31:0] row_data;
  logic [7:0]  row_index;
  logic        row_ready;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;

  fifo_row_collector #(.WIDTH(8), .COLS(4), .ROW_CNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .start(start), .num_rows(num_rows),
    .fifo_read_ready(fifo_read_ready), .fifo_read_data(fifo_read_data),
    .fifo_read_enable(fifo_read_enable), .row_valid(row_valid),
    .row_data(row_data), .row_index(row_index), .row_ready(row_ready),
    .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // FIFO model
  logic [7:0] fifo_q[$];
  logic       pop_pending = 1'b0;

  task automatic refresh();
    fifo_read_ready = (fifo_q.size() != 0);
    fifo_read_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] v);
    fifo_q.push_back(v);
    refresh();
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
    if (pop_pending && fifo_q.size() != 0) begin
      void'(fifo_q.pop_front());
    end
    pop_pending = 1'b0;
    refresh();
  endtask

  // Abstract job model: which job is running, which elements it has
  // taken so far for the current row, and how many rows were accepted.
  logic       armed = 1'b0;
  logic       m_active = 1'b0;
  logic       m_done_exp = 1'b0;
  int         m_num = 0;
  int         m_rows = 0;
  int         m_reads = 0;
  logic [7:0] m_pend[$];
  logic       exp_valid;
  logic       nd;

  function automatic logic [31:0] pack_row();
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (i < m_pend.size()) r[i*8 +: 8] = m_pend[i];
    end
    return r;
  endfunction

  // Per-cycle compare against the model, then advance the model to the coming edge.
  always @(negedge CLK) begin
    exp_valid = m_active && (m_pend.size() == 4);
    if (armed) begin
      check("m_row_valid", row_valid, exp_valid);
      check("m_read_enable", fifo_read_enable,
            m_active && (m_pend.size() < 4) && fifo_read_ready);
      check("m_busy", busy, m_active || m_done_exp);
      check("m_done", done, m_done_exp);
      if (exp_valid) begin
        check("m_row_data", row_data, pack_row());
        check("m_row_index", row_index, m_rows);
      end
    end
    pop_pending = (fifo_read_enable === 1'b1) && fifo_read_ready;
    if (RST) begin
      armed      = 1'b1;
      m_active   = 1'b0;
      m_done_exp = 1'b0;
      m_rows     = 0;
      m_pend.delete();
    end else begin
      nd = 1'b0;
      if (!m_active && !m_done_exp) begin
        if (start) begin
          if (num_rows == 8'd0) begin
            nd = 1'b1;
          end else begin
            m_active = 1'b1;
            m_num    = num_rows;
            m_rows   = 0;
            m_pend.delete();
          end
        end
      end else if (m_active) begin
        if (fifo_read_enable === 1'b1) begin
          m_pend.push_back(fifo_read_data);
          m_reads++;
        end
        if (exp_valid && row_ready) begin
          m_pend.delete();
          m_rows++;
          if (m_rows == m_num) begin
            m_active = 1'b0;
            nd = 1'b1;
          end
        end
      end
      m_done_exp = nd;
    end
  end

  task automatic do_start(input logic [7:0] n);
    num_rows = n;
    start    = 1'b1;
    cyc();
    start    = 1'b0;
  endtask

  task automatic wait_valid(input int max, input string name);
    int n = 0;
    while (row_valid !== 1'b1 && n < max) begin
      cyc();
      n++;
    end
    check({name, "_valid_timeout"}, row_valid, 1'b1);
  endtask

  int reads0;
  int rows_seen;
  int dones_seen;

  initial begin
    RST = 1'b1; start = 1'b0; num_rows = 8'd0; row_ready = 1'b1;
    refresh();
    cyc();
    cyc();
    check("rst_busy", busy, 1'b0);
    check("rst_row_valid", row_valid, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_read_enable", fifo_read_enable, 1'b0);
    check("rst_row_index", row_index, 8'd0);
    check("rst_row_data", row_data, 32'h0);
    RST = 1'b0;
    cyc();

    // Basic two-row job
    for (int i = 1; i <= 8; i++) push(8'(i));
    reads0 = m_reads;
    do_start(8'd2);
    wait_valid(20, "basic_r0");
    check("basic_r0_data", row_data, 32'h04030201);
    check("basic_r0_index", row_index, 8'd0);
    cyc();
    wait_valid(20, "basic_r1");
    check("basic_r1_data", row_data, 32'h08070605);
    check("basic_r1_index", row_index, 8'd1);
    cyc();
    check("basic_done_pulse", done, 1'b1);
    cyc();
    check("basic_done_clear", done, 1'b0);
    check("basic_idle", busy, 1'b0);
    check("basic_reads", m_reads - reads0, 8);

    // Empty FIFO stall
    do_start(8'd1);
    for (int i = 0; i < 5; i++) begin
      check("stall_no_read", fifo_read_enable, 1'b0);
      cyc();
    end
    for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
    cyc(); cyc(); cyc();
    check("stall_not_yet_valid", row_valid, 1'b0);
    cyc();
    check("stall_valid_after_4th", row_valid, 1'b1);
    check("stall_data", row_data, 32'hA3A2A1A0);
    cyc();
    check("stall_done", done, 1'b1);
    cyc();

    // Downstream backpressure
    row_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'h11 + 8'(i));
    do_start(8'd2);
    wait_valid(20, "bp_r0");
    for (int i = 0; i < 6; i++) begin
      check("bp_hold_data", row_data, 32'h14131211);
      check("bp_hold_index", row_index, 8'd0);
      check("bp_no_read", fifo_read_enable, 1'b0);
      cyc();
    end
    row_ready = 1'b1;
    cyc();
    check("bp_resume_read", fifo_read_enable, 1'b1);
    wait_valid(20, "bp_r1");
    check("bp_r1_data", row_data, 32'h18171615);
    check("bp_r1_index", row_index, 8'd1);
    cyc();
    check("bp_done", done, 1'b1);
    cyc();

    // Zero-row job
    reads0 = m_reads;
    do_start(8'd0);
    check("zero_done", done, 1'b1);
    check("zero_busy", busy, 1'b1);
    check("zero_no_valid", row_valid, 1'b0);
    cyc();
    check("zero_done_clear", done, 1'b0);
    check("zero_busy_clear", busy, 1'b0);
    check("zero_no_reads", m_reads - reads0, 0);

    // Start while busy is ignored
    do_start(8'd2);
    push(8'h31); push(8'h32);
    cyc(); cyc();
    do_start(8'd9);
    for (int i = 0; i < 6; i++) push(8'h33 + 8'(i));
    rows_seen = 0; dones_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (row_valid && row_ready) rows_seen++;
      if (done) dones_seen++;
      cyc();
    end
    check("busy_start_rows", rows_seen, 2);
    check("busy_start_dones", dones_seen, 1);
    check("busy_start_idle", busy, 1'b0);

    // Reset in the middle of a row
    do_start(8'd1);
    push(8'hB0); push(8'hB1);
    cyc(); cyc();
    RST = 1'b1;
    cyc();
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_valid", row_valid, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_index", row_index, 8'd0);
    RST = 1'b0;
    for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
    do_start(8'd1);
    wait_valid(20, "mid_rst_row");
    check("mid_rst_row_data", row_data, 32'hC3C2C1C0);
    check("mid_rst_row_index", row_index, 8'd0);
    cyc();
    check("mid_rst_done_pulse", done, 1'b1);
    cyc();
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
